// File: rtl/hex_display_scan_if.sv
// Display-scan bus: data/control into the scanner, digit select and decoder feed out.
interface hex_display_scan_if;
  logic [15:0] value;
  logic        load;
  logic        enable;
  logic        blank_lz;
  logic [3:0]  hex_digit;
  logic        display_on;
  logic [3:0]  anode;
  logic        frame_done;

  modport master (
    output value, load, enable, blank_lz,
    input  hex_digit, display_on, anode, frame_done
  );

  modport slave (
    input  value, load, enable, blank_lz,
    output hex_digit, display_on, anode, frame_done
  );
endinterface

// File: rtl/hex_display_scan.sv
// Four-digit multiplexed hex display scanner with frame-synchronous
// (tear-free) data updates and optional leading-zero blanking.
module hex_display_scan #(
  parameter int unsigned CLK_DIV = 50000,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  hex_display_scan_if.slave  bus
);

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      pending;
  logic             pend_valid;
  logic [15:0]      shown;

  logic             tick;
  logic             boundary;
  logic [1:0]       idx_nxt;
  logic [15:0]      shown_nxt;
  logic [3:0]       lz_blank;
  logic [3:0]       digit_nxt;

  // Next-state view; outputs are derived from it so they move with idx.
  always_comb begin
    tick      = (cnt == SLOT_LAST);
    boundary  = tick && (idx == 2'd3);
    idx_nxt   = tick ? idx + 2'd1 : idx;
    shown_nxt = shown;
    if (boundary) begin
      if (bus.load)
        shown_nxt = bus.value;
      else if (pend_valid)
        shown_nxt = pending;
    end
    lz_blank[0] = 1'b0;
    lz_blank[1] = (shown_nxt[15:4]  == 12'h000);
    lz_blank[2] = (shown_nxt[15:8]  == 8'h00);
    lz_blank[3] = (shown_nxt[15:12] == 4'h0);
    digit_nxt   = shown_nxt[{idx_nxt, 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt            <= '0;
      idx            <= 2'd0;
      pending        <= 16'h0000;
      pend_valid     <= 1'b0;
      shown          <= 16'h0000;
      bus.hex_digit  <= 4'h0;
      bus.display_on <= 1'b0;
      bus.anode      <= 4'b1111;
      bus.frame_done <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
      idx <= idx_nxt;
      if (bus.load)
        pending <= bus.value;
      // Boundary consumes any pending data, including a same-cycle load.
      if (boundary)
        pend_valid <= 1'b0;
      else if (bus.load)
        pend_valid <= 1'b1;
      shown          <= shown_nxt;
      bus.hex_digit  <= digit_nxt;
      bus.display_on <= bus.enable && !(bus.blank_lz && lz_blank[idx_nxt]);
      bus.anode      <= bus.enable ? ~(4'b0001 << idx_nxt) : 4'b1111;
      bus.frame_done <= boundary;
    end
  end

endmodule
